// File: rtl/cpu_pkg.sv
// Shared CPU package: register-file index/data types and the zero-register index.
package cpu_pkg;
  localparam logic [4:0] REG_ZERO = 5'd31;
  localparam int         DATA_W   = 64;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [63:0] xword_t;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback + ID read-port bundle for the architectural register file.
// master = pipeline side (WB/ID), slave = register file.
interface wb_regfile_if import cpu_pkg::*; #(
  parameter int DW    = DATA_W,
  parameter int CNT_W = 32
);
  logic             WbRegWrite;
  reg_idx_t         WbAw;
  logic [DW-1:0]    WbDataToReg;
  reg_idx_t         IdAa;
  reg_idx_t         IdAb;
  logic [DW-1:0]    IdDa;
  logic [DW-1:0]    IdDb;
  logic [CNT_W-1:0] WbRetired;

  modport master (
    output WbRegWrite, WbAw, WbDataToReg, IdAa, IdAb,
    input  IdDa, IdDb, WbRetired
  );

  modport slave (
    input  WbRegWrite, WbAw, WbDataToReg, IdAa, IdAb,
    output IdDa, IdDb, WbRetired
  );
endinterface

// File: rtl/wb_regfile_decoder.sv
// Write-enable decoder: one-hot of WbAw gated by WbRegWrite; the XZR slot never fires.
module wb_write_decoder import cpu_pkg::*; #(
  parameter int NREG = 32
) (
  input  logic            we,
  input  reg_idx_t        aw,
  output logic [NREG-1:0] wen
);
  // One-hot select, with the zero register masked so its writes are dropped.
  always_comb begin
    wen = '0;
    if (we) wen[aw] = 1'b1;
    wen[REG_ZERO] = 1'b0;
  end
endmodule

// File: rtl/wb_regfile_register.sv
// Generic enabled register with async active-high clear.
module register #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  // Load d when enabled; reset clears immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 32 x DW LEGv8 register file, XZR hardwired to zero, one WB write
// port, two combinational ID read ports, and a retired-write counter.
// Optional macro WB_BYPASS_EN: same-cycle write-through from WB to the read ports.
module wb_regfile import cpu_pkg::*; #(
  parameter int DW    = DATA_W,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  logic [NREG-1:0]         wen;
  logic [NREG-1:0][DW-1:0] rdata;
  logic [CNT_W-1:0]        cnt_q;
  logic [DW-1:0]           da, db;

  wb_write_decoder #(.NREG(NREG)) u_dec (
    .we  (bus.WbRegWrite),
    .aw  (bus.WbAw),
    .wen (wen)
  );

  // Storage for X0..X30; XZR has no storage and reads as zero.
  for (genvar i = 0; i < NREG - 1; i++) begin : g_reg
    register #(.N(DW)) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wen[i]),
      .d     (bus.WbDataToReg),
      .q     (rdata[i])
    );
  end
  assign rdata[NREG-1] = '0;

  // Retired-write counter; wraps silently at 2^CNT_W.
  register #(.N(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (|wen),
    .d     (cnt_q + 1'b1),
    .q     (cnt_q)
  );

  // Read muxes, followed by the optional write-through bypass.
  always_comb begin
    da = rdata[bus.IdAa];
    db = rdata[bus.IdAb];
`ifdef WB_BYPASS_EN
    if (bus.WbRegWrite && bus.WbAw != REG_ZERO && bus.WbAw == bus.IdAa) da = bus.WbDataToReg;
    if (bus.WbRegWrite && bus.WbAw != REG_ZERO && bus.WbAw == bus.IdAb) db = bus.WbDataToReg;
`else
`endif
  end

  assign bus.IdDa      = da;
  assign bus.IdDb      = db;
  assign bus.WbRetired = cnt_q;
endmodule
